// File: rtl/aes_pkg.sv
// AES round controller shared types: FSM encoding, key-size codes,
// default round counts and the key-size to round-count mapping.
package aes_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] KS_128 = 2'd0;
    localparam logic [1:0] KS_192 = 2'd1;
    localparam logic [1:0] KS_256 = 2'd2;
    localparam logic [1:0] KS_RSV = 2'd3;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

    // The reserved key-size code runs the 128-bit schedule.
    function automatic int nr_of(
        input logic [1:0] ks,
        input int         n128,
        input int         n192,
        input int         n256
    );
        case (ks)
            KS_192:         return n192;
            KS_256:         return n256;
            KS_128, KS_RSV: return n128;
            default:        return n128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-strobe bundle of the AES round controller.
// AES_ROUND_CTRL_ABORT_EN adds the core_abort request.
interface aes_round_ctrl_if #(
    parameter int RND_W = 4
);
    logic             core_start;
    logic [1:0]       key_size;
    logic             dec_mode;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic             core_abort;
`endif
    logic             core_ready;
    logic             core_done;
    logic [RND_W-1:0] rnd_num;
    logic             last_rnd;
    logic             key_ld;
    logic             data_ld;
    logic             key_en;
    logic             data_en;

`ifdef AES_ROUND_CTRL_ABORT_EN
    modport master (
        output core_start, key_size, dec_mode, core_abort,
        input  core_ready, core_done, rnd_num, last_rnd,
        input  key_ld, data_ld, key_en, data_en
    );
    modport slave (
        input  core_start, key_size, dec_mode, core_abort,
        output core_ready, core_done, rnd_num, last_rnd,
        output key_ld, data_ld, key_en, data_en
    );
`else
    modport master (
        output core_start, key_size, dec_mode,
        input  core_ready, core_done, rnd_num, last_rnd,
        input  key_ld, data_ld, key_en, data_en
    );
    modport slave (
        input  core_start, key_size, dec_mode,
        output core_ready, core_done, rnd_num, last_rnd,
        output key_ld, data_ld, key_en, data_en
    );
`endif

endinterface

// File: rtl/aes_rnd_cnt.sv
// Round counter: counts 0..nr while running, flags the final round
// and maps the count to an ascending or descending round-key index.
module aes_rnd_cnt #(
    parameter int RND_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    input  logic [RND_W-1:0] nr,
    input  logic             dec,
    output logic [RND_W-1:0] rnd_num,
    output logic             last_rnd
);

    logic [RND_W-1:0] rnd_cnt_q;
    logic [RND_W-1:0] rnd_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd_cnt_q <= '0;
        end else begin
            rnd_cnt_q <= rnd_cnt_d;
        end
    end

    // Counter rests at zero in IDLE, so a new start needs no extra clear.
    always_comb begin
        rnd_cnt_d = '0;
        if (run && !last_rnd && !clr) begin
            rnd_cnt_d = rnd_cnt_q + 1'b1;
        end
    end

    always_comb begin
        last_rnd = run && (rnd_cnt_q == nr);
        rnd_num  = '0;
        if (run) begin
            rnd_num = dec ? (nr - rnd_cnt_q) : rnd_cnt_q;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: IDLE/RUN FSM driving key/data strobes and round index.
// Define AES_ROUND_CTRL_ABORT_EN to build in the core_abort path.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int RND_W  = 4,
    parameter int NR_128 = NR_128_DEF,
    parameter int NR_192 = NR_192_DEF,
    parameter int NR_256 = NR_256_DEF
) (
    input logic             clk,
    input logic             reset,
    aes_round_ctrl_if.slave bus
);

    state_e           state_q;
    state_e           state_d;
    logic [RND_W-1:0] nr_q;
    logic [RND_W-1:0] nr_d;
    logic             dec_q;
    logic             dec_d;
    logic             done_q;
    logic             done_d;

    logic             abort;
    logic             idle;
    logic             run;
    logic             start_ok;
    logic             last_rnd;
    logic [RND_W-1:0] rnd_num;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort = bus.core_abort;
`else
    assign abort = 1'b0;
`endif

    assign idle     = (state_q == S_IDLE);
    assign run      = (state_q == S_RUN);
    // Abort outranks a start request in IDLE.
    assign start_ok = idle && bus.core_start && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            nr_q    <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                    nr_d    = RND_W'(nr_of(bus.key_size,
                                           NR_128, NR_192, NR_256));
                    dec_d   = bus.dec_mode;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_rnd) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.core_ready = idle;
        bus.core_done  = done_q;
        bus.rnd_num    = rnd_num;
        bus.last_rnd   = last_rnd;
        bus.key_ld     = idle;
        bus.data_ld    = start_ok;
        bus.key_en     = run;
        bus.data_en    = run;
    end

    aes_rnd_cnt #(
        .RND_W (RND_W)
    ) u_rnd_cnt (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .clr      (abort),
        .nr       (nr_q),
        .dec      (dec_q),
        .rnd_num  (rnd_num),
        .last_rnd (last_rnd)
    );

endmodule
